shuffle_scheduler: RTL and testbench

- Sequences one 8-lane coefficient shuffle for the 2D-array polynomial multiplier.
- Accepts a batch of 8 data words, each tagged with a 3-bit destination lane, and issues them to the destination lanes over one or more rounds.
- In each round, every destination lane receives the lowest-indexed pending source that targets it.
- Sources that collide on a destination are deferred to later rounds. A batch therefore takes 1 to 8 output beats.

---
 rtl/shuffle_scheduler.sv | 143 ++++++++++++++
 tb/tb_shuffle_scheduler.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/shuffle_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : shuffle_scheduler
// Description : Issues one 8-lane coefficient shuffle batch over 1..8 beats.
//               Each round, every destination lane takes the lowest-indexed
//               pending source aimed at it; colliding sources wait for later
//               rounds.
// Revision    : 1.0 - initial release
// ============================================================================
module shuffle_scheduler #(
  parameter int DW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [8*DW-1:0] in_data,
  input  logic [23:0]     in_dst,
  input  logic [7:0]      in_mask,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [8*DW-1:0] out_data,
  output logic [7:0]      out_lane_vld,
  output logic [23:0]     out_src,
  output logic [2:0]      out_round,
  output logic            out_last,
  output logic            busy
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] data_q [8];
  logic [DW-1:0] data_d [8];
  logic [2:0]    dst_q  [8];
  logic [2:0]    dst_d  [8];
  logic [7:0]    pending_q, pending_d;
  logic [2:0]    round_q, round_d;

  logic [7:0]    w_lane_vld;
  logic [2:0]    w_src [8];
  logic [7:0]    w_granted;
  logic          w_last;
  logic          w_accept;

  // Grant arbitration: derived from registers only, so it holds steady under stall.
  // Scanning sources high-to-low lets the lowest-indexed match win.
  always_comb begin
    w_lane_vld = '0;
    w_granted  = '0;
    for (int j = 0; j < 8; j++) begin
      w_src[j] = '0;
    end
    for (int j = 0; j < 8; j++) begin
      for (int i = 7; i >= 0; i--) begin
        if (pending_q[i] && (dst_q[i] == 3'(j))) begin
          w_lane_vld[j] = 1'b1;
          w_src[j]      = 3'(i);
        end
      end
    end
    for (int j = 0; j < 8; j++) begin
      if (w_lane_vld[j]) begin
        w_granted[w_src[j]] = 1'b1;
      end
    end
  end

  // Output drive: ungranted lanes and the idle state present zeros.
  always_comb begin
    out_data     = '0;
    out_src      = '0;
    out_lane_vld = w_lane_vld;
    for (int j = 0; j < 8; j++) begin
      if (w_lane_vld[j]) begin
        out_data[j*DW +: DW] = data_q[w_src[j]];
        out_src[j*3 +: 3]    = w_src[j];
      end
    end
    w_last    = (state_q == ISSUE) && ((pending_q & ~w_granted) == 8'h00);
    out_last  = w_last;
    out_round = round_q;
    out_valid = (state_q == ISSUE);
    busy      = (state_q == ISSUE);
    in_ready  = (state_q == IDLE) || ((state_q == ISSUE) && out_ready && w_last);
    w_accept  = in_valid && in_ready;
  end

  // Next-state: load on accept, retire granted sources per consumed beat.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    round_d   = round_q;
    for (int i = 0; i < 8; i++) begin
      data_d[i] = data_q[i];
      dst_d[i]  = dst_q[i];
    end
    if (w_accept) begin
      state_d   = ISSUE;
      pending_d = in_mask;
      round_d   = '0;
      for (int i = 0; i < 8; i++) begin
        data_d[i] = in_data[i*DW +: DW];
        dst_d[i]  = in_dst[i*3 +: 3];
      end
    end else if ((state_q == ISSUE) && out_ready) begin
      if (!w_last) begin
        pending_d = pending_q & ~w_granted;
        round_d   = round_q + 3'd1;
      end else begin
        pending_d = '0;
        round_d   = '0;
        state_d   = IDLE;
      end
    end
  end

  // State and batch registers; reset abandons any batch in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      round_q   <= '0;
      for (int i = 0; i < 8; i++) begin
        data_q[i] <= '0;
        dst_q[i]  <= '0;
      end
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      round_q   <= round_d;
      for (int i = 0; i < 8; i++) begin
        data_q[i] <= data_d[i];
        dst_q[i]  <= dst_d[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_shuffle_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_shuffle_scheduler
// Description : Directed self-checking bench for shuffle_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shuffle_scheduler;
  localparam int DW = 16;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [8*DW-1:0] in_data;
  logic [23:0]     in_dst;
  logic [7:0]      in_mask;
  logic            out_valid;
  logic            out_ready;
  logic [8*DW-1:0] out_data;
  logic [7:0]      out_lane_vld;
  logic [23:0]     out_src;
  logic [2:0]      out_round;
  logic            out_last;
  logic            busy;

  int checks = 0;
  int errors = 0;

  shuffle_scheduler #(.DW(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_dst       (in_dst),
    .in_mask      (in_mask),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_lane_vld (out_lane_vld),
    .out_src      (out_src),
    .out_round    (out_round),
    .out_last     (out_last),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data vector with lane i = base + i
  function automatic logic [8*DW-1:0] mk_data(input logic [DW-1:0] base);
    logic [8*DW-1:0] d;
    for (int i = 0; i < 8; i++) d[i*DW +: DW] = base + DW'(i);
    return d;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer a batch for one cycle (caller ensures in_ready is high).
  task automatic send(input logic [8*DW-1:0] d, input logic [23:0] t, input logic [7:0] m);
    in_data  = d;
    in_dst   = t;
    in_mask  = m;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
    checks++; if (out_lane_vld !== 8'h00) begin errors++; $display("FAIL reset_lane_vld got %h want 00", out_lane_vld); end
    checks++; if (out_src !== 24'h0) begin errors++; $display("FAIL reset_out_src got %h want 0", out_src); end
    checks++; if (out_round !== 3'd0) begin errors++; $display("FAIL reset_round got %0d want 0", out_round); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_last got %b want 0", out_last); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
  endtask

  task automatic test_identity();
    logic [8*DW-1:0] d;
    d = mk_data(16'h0100);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL id_idle_ready got %b want 1", in_ready); end
    send(d, 24'o76543210, 8'hFF);
    checks++; if (out_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL id_valid got %b/%b want 1/1", out_valid, busy); end
    checks++; if (out_lane_vld !== 8'hFF) begin errors++; $display("FAIL id_lane_vld got %h want FF", out_lane_vld); end
    checks++; if (out_data !== d) begin errors++; $display("FAIL id_data got %h want %h", out_data, d); end
    checks++; if (out_src !== 24'o76543210) begin errors++; $display("FAIL id_src got %o want 76543210", out_src); end
    checks++; if (out_round !== 3'd0 || out_last !== 1'b1) begin errors++; $display("FAIL id_round_last got %0d/%b want 0/1", out_round, out_last); end
    step();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL id_back_idle got %b/%b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_reverse();
    logic [8*DW-1:0] d, e;
    d = mk_data(16'h0200);
    for (int j = 0; j < 8; j++) e[j*DW +: DW] = 16'h0200 + 16'(7 - j);
    send(d, 24'o01234567, 8'hFF);
    checks++; if (out_lane_vld !== 8'hFF) begin errors++; $display("FAIL rev_lane_vld got %h want FF", out_lane_vld); end
    checks++; if (out_src !== 24'o01234567) begin errors++; $display("FAIL rev_src got %o want 01234567", out_src); end
    checks++; if (out_data !== e) begin errors++; $display("FAIL rev_data got %h want %h", out_data, e); end
    checks++; if (out_last !== 1'b1) begin errors++; $display("FAIL rev_last got %b want 1", out_last); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rev_done got %b want 0", out_valid); end
  endtask

  task automatic test_full_collision();
    logic [8*DW-1:0] e;
    send(mk_data(16'h0300), 24'o33333333, 8'hFF);
    for (int b = 0; b < 8; b++) begin
      e = '0;
      e[3*DW +: DW] = 16'h0300 + 16'(b);
      checks++; if (out_valid !== 1'b1 || out_lane_vld !== 8'h08) begin errors++; $display("FAIL coll_vld beat %0d got %b/%h want 1/08", b, out_valid, out_lane_vld); end
      checks++; if (out_src !== {12'o0000, 3'(b), 9'o000}) begin errors++; $display("FAIL coll_src beat %0d got %o want src3=%0d", b, out_src, b); end
      checks++; if (out_data !== e) begin errors++; $display("FAIL coll_data beat %0d got %h want %h", b, out_data, e); end
      checks++; if (out_round !== 3'(b)) begin errors++; $display("FAIL coll_round beat %0d got %0d want %0d", b, out_round, b); end
      checks++; if (out_last !== (b == 7)) begin errors++; $display("FAIL coll_last beat %0d got %b want %b", b, out_last, (b == 7)); end
      step();
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL coll_done got %b want 0", out_valid); end
  endtask

  task automatic test_partial();
    logic [7:0]  vld_t [3];
    logic [23:0] src_t [3];
    logic [8*DW-1:0] e;
    vld_t[0] = 8'h07; src_t[0] = 24'o00000420;
    vld_t[1] = 8'h07; src_t[1] = 24'o00000531;
    vld_t[2] = 8'h04; src_t[2] = 24'o00000600;
    send(mk_data(16'h0400), 24'o52221100, 8'h7F);
    for (int b = 0; b < 3; b++) begin
      e = '0;
      for (int j = 0; j < 8; j++)
        if (vld_t[b][j]) e[j*DW +: DW] = 16'h0400 + 16'(src_t[b][j*3 +: 3]);
      checks++; if (out_lane_vld !== vld_t[b]) begin errors++; $display("FAIL part_vld beat %0d got %h want %h", b, out_lane_vld, vld_t[b]); end
      checks++; if (out_src !== src_t[b]) begin errors++; $display("FAIL part_src beat %0d got %o want %o", b, out_src, src_t[b]); end
      checks++; if (out_data !== e) begin errors++; $display("FAIL part_data beat %0d got %h want %h", b, out_data, e); end
      checks++; if (out_round !== 3'(b) || out_last !== (b == 2)) begin errors++; $display("FAIL part_round_last beat %0d got %0d/%b want %0d/%b", b, out_round, out_last, b, (b == 2)); end
      step();
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL part_done got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    send(mk_data(16'h0500), 24'o52221100, 8'h7F);
    out_ready = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (out_valid !== 1'b1 || out_lane_vld !== 8'h07 || out_src !== 24'o00000420 || out_round !== 3'd0)
        begin errors++; $display("FAIL bp_hold cycle %0d got v=%b vld=%h src=%o r=%0d want 1/07/420/0", c, out_valid, out_lane_vld, out_src, out_round); end
      checks++; if (out_data[2*DW +: DW] !== 16'h0504) begin errors++; $display("FAIL bp_hold_data cycle %0d got %h want 0504", c, out_data[2*DW +: DW]); end
    end
    out_ready = 1'b1;
    step();
    checks++; if (out_round !== 3'd1 || out_src !== 24'o00000531) begin errors++; $display("FAIL bp_beat1 got r=%0d src=%o want 1/531", out_round, out_src); end
    step();
    checks++; if (out_last !== 1'b1 || out_round !== 3'd2) begin errors++; $display("FAIL bp_beat2 got last=%b r=%0d want 1/2", out_last, out_round); end
    // Present the identity batch during the last-beat handshake
    in_data = mk_data(16'h0600); in_dst = 24'o76543210; in_mask = 8'hFF; in_valid = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b want 1", in_ready); end
    step();
    checks++; if (out_valid !== 1'b1 || out_round !== 3'd0 || out_lane_vld !== 8'hFF || out_last !== 1'b1)
      begin errors++; $display("FAIL b2b_beat got v=%b r=%0d vld=%h last=%b want 1/0/FF/1", out_valid, out_round, out_lane_vld, out_last); end
    checks++; if (out_data !== mk_data(16'h0600)) begin errors++; $display("FAIL b2b_data got %h want lanes 0600+j", out_data); end
    // Empty-mask batch chained straight after
    in_mask = 8'h00;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL empty_ready got %b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_lane_vld !== 8'h00 || out_last !== 1'b1 || out_round !== 3'd0)
      begin errors++; $display("FAIL empty_beat got v=%b vld=%h last=%b r=%0d want 1/00/1/0", out_valid, out_lane_vld, out_last, out_round); end
    checks++; if (out_data !== '0 || out_src !== 24'h0) begin errors++; $display("FAIL empty_data got %h/%o want 0/0", out_data, out_src); end
    step();
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL empty_done got %b/%b want 0/0", out_valid, busy); end
  endtask

  task automatic test_reset_mid_batch();
    send(mk_data(16'h0700), 24'o33333333, 8'hFF);
    step();
    step();
    checks++; if (out_round !== 3'd2) begin errors++; $display("FAIL rst_mid_round got %0d want 2", out_round); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_async got v=%b rdy=%b want 0/1", out_valid, in_ready); end
    checks++; if (out_lane_vld !== 8'h00 || busy !== 1'b0 || out_round !== 3'd0) begin errors++; $display("FAIL rst_mid_outs got vld=%h busy=%b r=%0d want 00/0/0", out_lane_vld, busy, out_round); end
    #2;
    rst_n = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_no_resume got %b want 0", out_valid); end
    send(mk_data(16'h0800), 24'o76543210, 8'hFF);
    checks++; if (out_lane_vld !== 8'hFF || out_last !== 1'b1 || out_round !== 3'd0)
      begin errors++; $display("FAIL rst_mid_fresh got vld=%h last=%b r=%0d want FF/1/0", out_lane_vld, out_last, out_round); end
    checks++; if (out_data !== mk_data(16'h0800)) begin errors++; $display("FAIL rst_mid_fresh_data got %h want lanes 0800+j", out_data); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_fresh_done got %b want 0", out_valid); end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_dst    = '0;
    in_mask   = '0;
    out_ready = 1'b1;
    #3;
    test_reset();
    #10;
    rst_n = 1'b1;
    step();
    test_identity();
    test_reverse();
    test_full_collision();
    test_partial();
    test_back_to_back();
    test_reset_mid_batch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop in case the sequence stalls.
  initial begin
    #100000;
    $display("FAIL timeout sim_time %0t want completion", $time);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
